// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the divide issue/retire controller.
package div_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DBZ,
        RESULT
    } div_state_e;

    // Two's-complement negate with 32-bit wrap when neg is set, so |0x8000_0000| stays 0x8000_0000.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous first-word-fall-through request FIFO; DEPTH must be a power of two.
module div_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues queued divide requests to a multicycle combinational divider and
// returns sign-corrected results on a valid/ready port.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TAG_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              in_signed,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [31:0]       div_a,
    output logic [31:0]       div_b,
    input  logic [31:0]       div_q,
    input  logic [31:0]       div_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_q,
    output logic [31:0]       out_r,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_dbz
);

    localparam int unsigned ENTRY_W = 2 * DATA_W + 1 + TAG_W;
    localparam int unsigned CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               e_signed;
    logic [TAG_W-1:0]   e_tag;
    logic [DATA_W-1:0]  e_a;
    logic [DATA_W-1:0]  e_b;

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  opa_q, opa_d;
    logic [DATA_W-1:0]  opb_q, opb_d;
    logic [DATA_W-1:0]  dividend_q, dividend_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  quo_q, quo_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [TAG_W-1:0]   otag_q, otag_d;
    logic               dbz_q, dbz_d;

    div_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i ({in_signed, in_tag, in_a, in_b}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {e_signed, e_tag, e_a, e_b} = head;

    assign in_ready  = !fifo_full;
    assign div_a     = opa_q;
    assign div_b     = opb_q;
    assign out_valid = valid_q;
    assign out_q     = quo_q;
    assign out_r     = rem_q;
    assign out_tag   = otag_q;
    assign out_dbz   = dbz_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        dividend_d = dividend_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        otag_d     = otag_q;
        dbz_d      = dbz_q;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                pop = !fifo_empty;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    quo_d   = cond_neg(div_q, neg_quo_q);
                    rem_d   = cond_neg(div_r, neg_rem_q);
                    otag_d  = tag_q;
                    dbz_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DBZ: begin
                quo_d   = DBZ_QUOTIENT;
                rem_d   = dividend_q;
                otag_d  = tag_q;
                dbz_d   = 1'b1;
                valid_d = 1'b1;
                state_d = RESULT;
            end
            RESULT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    pop     = !fifo_empty;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop always reloads the divider operands; it overrides the state chosen above.
        if (pop) begin
            opa_d      = cond_neg(e_a, e_signed && e_a[31]);
            opb_d      = cond_neg(e_b, e_signed && e_b[31]);
            dividend_d = e_a;
            neg_quo_d  = e_signed && (e_a[31] ^ e_b[31]);
            neg_rem_d  = e_signed && e_a[31];
            tag_d      = e_tag;
            cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
            state_d    = (e_b == '0) ? DBZ : SETTLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            dividend_q <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            otag_q     <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            dividend_q <= dividend_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            otag_q     <= otag_d;
            dbz_q      <= dbz_d;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural combinational divider.
module tb_div_issue_ctrl;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0]      q;
        logic [31:0]      r;
        logic             dbz;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [31:0]      div_q;
    logic [31:0]      div_r;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_q;
    logic [31:0]      out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_dbz;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .DEPTH         (4),
        .SETTLE_CYCLES (2),
        .TAG_W         (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .out_dbz   (out_dbz)
    );

    // Divider environment model
    always_comb begin
        if (div_b == 32'd0) begin
            div_q = 32'hFFFF_FFFF;
            div_r = div_a;
        end else begin
            div_q = div_a / div_b;
            div_r = div_a % div_b;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted result against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got q=%h r=%h tag=%h expected none", out_q,
                         out_r, out_tag);
            end else begin
                mon_e = sb.pop_front();
                check("result_q", out_q, mon_e.q);
                check("result_r", out_r, mon_e.r);
                check("result_dbz", {31'd0, out_dbz}, {31'd0, mon_e.dbz});
                check("result_tag", {28'd0, out_tag}, {28'd0, mon_e.tag});
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [TAG_W-1:0] tag, input logic [31:0] eq,
                        input logic [31:0] er, input logic edbz);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got in_ready=0 expected 1");
            return;
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
        sb.push_back('{q: eq, r: er, dbz: edbz, tag: tag});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_dbz", out_dbz, 0);
        check("rst_out_q", out_q, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_div_a", div_a, 0);
        check("rst_div_b", div_b, 0);

        // Unsigned 100/7 latency
        out_ready = 1'b1;
        push(32'd100, 32'd7, 1'b0, 4'd1, 32'd14, 32'd2, 1'b0);
        @(posedge clk); #1;
        check("lat_e1_valid", out_valid, 0);
        check("lat_e1_div_a", div_a, 32'd100);
        check("lat_e1_div_b", div_b, 32'd7);
        @(posedge clk); #1;
        check("lat_e2_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_e3_valid", out_valid, 1);
        wait_drain();

        // Unsigned 5/0 latency
        push(32'd5, 32'd0, 1'b0, 4'd2, 32'hFFFF_FFFF, 32'd5, 1'b1);
        @(posedge clk); #1;
        check("dbz_e1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("dbz_e2_valid", out_valid, 1);
        check("dbz_e2_flag", out_dbz, 1);
        wait_drain();

        // Signed corner cases back to back
        push(32'hFFFF_FFF9, 32'd2, 1'b1, 4'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        push(32'd7, 32'hFFFF_FFFE, 1'b1, 4'd4, 32'hFFFF_FFFD, 32'd1, 1'b0);
        push(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd5, 32'h8000_0000, 32'd0, 1'b0);
        push(32'hFFFF_FFFB, 32'd0, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        push(32'hFFFF_FFF9, 32'd2, 1'b0, 4'd7, 32'h7FFF_FFFC, 32'd1, 1'b0);
        wait_drain();

        // Fill the FIFO with the consumer stalled
        out_ready = 1'b0;
        push(32'd1000, 32'd10, 1'b0, 4'd1, 32'd100, 32'd0, 1'b0);
        push(32'd77, 32'd5, 1'b0, 4'd2, 32'd15, 32'd2, 1'b0);
        push(32'd9, 32'd0, 1'b0, 4'd3, 32'hFFFF_FFFF, 32'd9, 1'b1);
        push(32'hFFFF_FFEC, 32'd3, 1'b1, 4'd4, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 1'b0);
        push(32'd50, 32'd7, 1'b0, 4'd5, 32'd7, 32'd1, 1'b0);
        check("full_in_ready", in_ready, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_q", out_q, 32'd100);
            check("hold_r", out_r, 32'd0);
            check("hold_tag", out_tag, 32'd1);
            check("hold_div_a", div_a, 32'd1000);
            check("hold_div_b", div_b, 32'd10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rel_e1_valid", out_valid, 0);
        check("rel_e1_div_a", div_a, 32'd77);
        @(posedge clk); #1;
        check("rel_e2_valid", out_valid, 0);
        @(posedge clk); #1;
        check("rel_e3_valid", out_valid, 1);
        check("rel_e3_tag", out_tag, 32'd2);
        wait_drain();
        check("drained_in_ready", in_ready, 1);

        // Reset during SETTLE with three requests queued
        out_ready = 1'b0;
        push(32'd30, 32'd4, 1'b0, 4'd1, 32'd7, 32'd2, 1'b0);
        push(32'd10, 32'd3, 1'b0, 4'd2, 32'd3, 32'd1, 1'b0);
        push(32'd11, 32'd2, 1'b0, 4'd3, 32'd5, 32'd1, 1'b0);
        push(32'd12, 32'd5, 1'b0, 4'd4, 32'd2, 32'd2, 1'b0);
        push(32'd13, 32'd6, 1'b0, 4'd5, 32'd2, 32'd1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pre_rst_valid", out_valid, 0);
        check("pre_rst_div_a", div_a, 32'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_div_a", div_a, 0);
        check("flush_div_b", div_b, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check("no_stale_valid", out_valid, 0);
        end
        push(32'd81, 32'd9, 1'b0, 4'd9, 32'd9, 32'd0, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Sequential issue/retire controller in front of the 32-bit combinational unsigned divider. It buffers divide requests in a small FIFO and converts signed operands to magnitudes. It holds the divider inputs stable for a programmable multicycle settle window, then captures and sign-corrects the quotient and remainder. Results go to a valid/ready output port, with divide-by-zero flagged.

## Interface
- DEPTH, 4: request FIFO entries (power of two, ≥2)
- SETTLE_CYCLES, 2: clock edges the divider inputs are held before capture (≥1)
- TAG_W, 4: width of the opaque request tag
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  FIFO can accept; equals !full
- in_a  in  32  dividend
- in_b  in  32  divisor
- in_signed  in  1  1 = two's-complement divide, 0 = unsigned
- in_tag  in  TAG_W  returned with the result
- div_a  out  32  registered unsigned dividend to divider
- div_b  out  32  registered unsigned divisor to divider
- div_q  in  32  divider quotient (combinational from div_a/div_b)
- div_r  in  32  divider remainder
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_q, out_r  out  32 each  corrected quotient / remainder
- out_tag  out  TAG_W  tag of the request
- out_dbz  out  1  divisor was zero

## Operation
- FIFO push on in_valid & in_ready. No bypass: every request passes through the FIFO.
- FSM states are IDLE, SETTLE, DBZ, RESULT.
- IDLE → pop when the FIFO is non-empty. Load div_a = |a|, div_b = |b|, latch neg_q = signed & (a[31]^b[31]), neg_r = signed & a[31], tag, and the original a.
  - If b == 0 → DBZ.
  - Otherwise → SETTLE with cnt = SETTLE_CYCLES-1.
- SETTLE decrements cnt. At cnt == 0, register out_q = neg_q ? -div_q : div_q and out_r = neg_r ? -div_r : div_r, set out_valid, → RESULT.
- DBZ: next edge register out_q = 32'hFFFF_FFFF, out_r = original a (unmodified, either mode), out_dbz = 1. → RESULT.
- RESULT holds all out_* stable until out_valid & out_ready.
  - On that edge, if the FIFO is non-empty, pop immediately (load as in IDLE) → SETTLE or DBZ.
  - Otherwise → IDLE.
- Magnitude is the two's-complement negate, 32-bit wrap. Signed 0x8000_0000 / 0xFFFF_FFFF gives |a| = 0x8000_0000, q = 0x8000_0000, r = 0 with no special case.
- out_dbz = 0 for every non-zero divisor.
- Simultaneous push and pop in the same edge are both honoured. in_ready depends only on FIFO count, never on out_ready.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_dbz = 0, out_q = out_r = 0, out_tag = 0, div_a = div_b = 0, FSM = IDLE, FIFO empty.
- Normal divide, with the request accepted at edge 0 and out_ready held high:
  - edge 1 loads div_a/div_b;
  - edge 1+SETTLE_CYCLES registers the result;
  - out_valid is high from then.
- Divide by zero: result registered at edge 2.
- Back-to-back throughput is one result per SETTLE_CYCLES+1 edges (DBZ: 2).
- div_a/div_b change only on a pop edge and are stable for the whole SETTLE window. The divider path is constrained as SETTLE_CYCLES-cycle multicycle.
- Full FIFO: in_ready = 0. A push in the edge a pop frees space is not accepted (in_ready is registered-count based).
- rst asserted mid-operation: the next edge flushes the FIFO, drops out_valid and returns to IDLE. The in-flight result is discarded.

## Structure
- Package div_pkg holds:
  - DATA_W = 32;
  - the state enum {IDLE, SETTLE, DBZ, RESULT};
  - DBZ_QUOTIENT = 32'hFFFF_FFFF;
  - the magnitude/negate helper function.
- Sub-module div_req_fifo is a parameterised synchronous FIFO (DEPTH × (64+1+TAG_W)) with push/pop/full/empty.
- The Divider instance lives in the parent; this block only drives div_a/div_b and samples div_q/div_r.

## Test plan
- Unsigned 100/7, SETTLE_CYCLES = 2, out_ready = 1 → out_q = 14, out_r = 2, out_dbz = 0, out_valid rises at edge 3.
- Signed −7/2 → q = 0xFFFF_FFFD (−3), r = 0xFFFF_FFFF (−1). Signed 7/−2 → q = −3, r = 1.
- Signed 0x8000_0000 / 0xFFFF_FFFF → q = 0x8000_0000, r = 0. Unsigned 5/0 → q = 0xFFFF_FFFF, r = 5, out_dbz = 1, out_valid at edge 2.
- Push 5 requests with out_ready = 0 → in_ready drops after 4 queued plus 1 popped into SETTLE. Results then drain in order with correct tags and no loss.
- Hold out_ready low for 10 cycles on a result → out_* unchanged and div_a/div_b unchanged. Release → next result follows SETTLE_CYCLES+1 edges later.
- Assert rst during SETTLE with 3 queued → out_valid = 0, in_ready = 1, div_a = div_b = 0. No stale result appears afterwards.
